// File: rtl/fpu_denorm_pkg.sv
// Shared types and helpers for the right-shift denormaliser: FSM states,
// working width {mant, guard, round}, shift saturation limit and step count.
package fpu_denorm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } denorm_state_e;

  localparam int DEF_LEN      = 32;
  localparam int DEF_MAX_STEP = 8;

  function automatic int work_width(input int len);
    return len + 2;
  endfunction

  // Shifting past the round position only feeds sticky, so larger amounts saturate here.
  function automatic int sat_limit(input int len);
    return len + 2;
  endfunction

  function automatic int num_steps(input int seff, input int max_step);
    if (seff == 0) return 1;
    return (seff + max_step - 1) / max_step;
  endfunction

endpackage

// File: rtl/fpu_denorm_step.sv
// One combinational right-shift step of the working register, folding the
// bits that fall off the bottom into the sticky bit.
module fpu_denorm_step #(
  parameter int WW  = 34,
  parameter int K_W = 7
) (
  input  logic [WW-1:0]  i_w,
  input  logic           i_s,
  input  logic [K_W-1:0] i_k,
  output logic [WW-1:0]  o_w,
  output logic           o_s
);

  logic [WW-1:0] w_mask;

  assign w_mask = ~({WW{1'b1}} << i_k);
  assign o_w    = i_w >> i_k;
  assign o_s    = i_s | (|(i_w & w_mask));

endmodule

// File: rtl/fpu_denorm_shift.sv
// Multi-cycle right-shift denormaliser producing mantissa + guard/round/sticky.
// Optional FPU_DENORM_EARLY_EXIT_EN: finish as soon as the working register is all zero.
module fpu_denorm_shift
  import fpu_denorm_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int MAX_STEP = 8,
  parameter int SHIFT_W  = $clog2(LEN) + 2
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               Valid_SI,
  output logic               Ready_SO,
  input  logic [LEN-1:0]     Mant_DI,
  input  logic [SHIFT_W-1:0] Shift_DI,
  input  logic               Kill_SI,
  output logic               Valid_SO,
  input  logic               Ready_SI,
  output logic [LEN-1:0]     Mant_DO,
  output logic               Guard_DO,
  output logic               Round_DO,
  output logic               Sticky_DO,
  output logic               Busy_SO
);

  localparam int                 WW     = work_width(LEN);
  localparam logic [SHIFT_W-1:0] SAT_V  = SHIFT_W'(sat_limit(LEN));
  localparam logic [SHIFT_W-1:0] STEP_V = SHIFT_W'(MAX_STEP);

  denorm_state_e      r_state, w_state_nxt;
  logic [WW-1:0]      r_w, w_w_step;
  logic               r_s, w_s_step;
  logic [SHIFT_W-1:0] r_cnt, w_cnt_nxt, w_k, w_seff;
  logic               w_accept, w_step_last;

  assign w_seff    = (Shift_DI > SAT_V) ? SAT_V : Shift_DI;
  assign w_k       = (r_cnt > STEP_V) ? STEP_V : r_cnt;
  assign w_cnt_nxt = r_cnt - w_k;
  // Kill wins over a same-cycle handshake, so the operand is dropped.
  assign w_accept  = Valid_SI & (r_state == IDLE) & ~Kill_SI;

  fpu_denorm_step #(
    .WW  (WW),
    .K_W (SHIFT_W)
  ) u_step (
    .i_w (r_w),
    .i_s (r_s),
    .i_k (w_k),
    .o_w (w_w_step),
    .o_s (w_s_step)
  );

`ifdef FPU_DENORM_EARLY_EXIT_EN
  assign w_step_last = (w_cnt_nxt == '0) || (w_w_step == '0);
`else
  assign w_step_last = (w_cnt_nxt == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (Kill_SI || w_step_last) w_state_nxt = Kill_SI ? IDLE : DONE;
      DONE:    if (Kill_SI || Ready_SI) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_w   <= {Mant_DI, 2'b00};
        r_s   <= 1'b0;
        r_cnt <= w_seff;
      end else if ((r_state == SHIFT) && !Kill_SI) begin
        r_w   <= w_w_step;
        r_s   <= w_s_step;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign Ready_SO  = (r_state == IDLE);
  assign Valid_SO  = (r_state == DONE);
  assign Busy_SO   = (r_state != IDLE);
  assign Mant_DO   = r_w[WW-1:2];
  assign Guard_DO  = r_w[1];
  assign Round_DO  = r_w[0];
  assign Sticky_DO = r_s;

endmodule

// File: tb/tb_fpu_denorm_shift.sv
// Scoreboard bench for fpu_denorm_shift at LEN=32, MAX_STEP=8.
module tb_fpu_denorm_shift;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_si, ready_so, kill_si, valid_so, ready_si;
  logic [31:0] mant_di, mant_do;
  logic [6:0]  shift_di;
  logic        guard_do, round_do, sticky_do, busy_so;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] mant;
    logic        g;
    logic        r;
    logic        s;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_denorm_shift dut (
    .Clk_CI    (clk),
    .Rst_RBI   (rst_n),
    .Valid_SI  (valid_si),
    .Ready_SO  (ready_so),
    .Mant_DI   (mant_di),
    .Shift_DI  (shift_di),
    .Kill_SI   (kill_si),
    .Valid_SO  (valid_so),
    .Ready_SI  (ready_si),
    .Mant_DO   (mant_do),
    .Guard_DO  (guard_do),
    .Round_DO  (round_do),
    .Sticky_DO (sticky_do),
    .Busy_SO   (busy_so)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: one wide shift of {mant,g,r} over 64 spare low bits; sticky is their OR.
  function automatic exp_t model(input logic [31:0] m, input int sh);
    exp_t         e;
    logic [127:0] v;
    logic [33:0]  w0;
    int           seff, n, s_i;
    seff = (sh > 34) ? 34 : sh;
    v    = {30'b0, m, 2'b00, 64'b0} >> seff;
    e.mant = v[97:66];
    e.g    = v[65];
    e.r    = v[64];
    e.s    = |v[63:0];
    n      = (seff == 0) ? 1 : (seff + 7) / 8;
    e.lat  = n;
`ifdef FPU_DENORM_EARLY_EXIT_EN
    w0 = {m, 2'b00};
    for (int i = 1; i <= n; i++) begin
      s_i = (8 * i < seff) ? 8 * i : seff;
      if ((w0 >> s_i) == 34'd0) begin
        e.lat = i;
        break;
      end
    end
`else
    w0  = '0;
    s_i = 0;
`endif
    return e;
  endfunction

  task automatic send(input logic [31:0] m, input int sh);
    @(negedge clk);
    chk("ready_before_send", {63'b0, ready_so}, 64'd1);
    valid_si = 1'b1;
    mant_di  = m;
    shift_di = 7'(sh);
    @(posedge clk);
    #1;
    valid_si = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] m, input int sh, input int hold);
    exp_t e;
    int   cnt;
    logic [31:0] held_mant;
    sb.push_back(model(m, sh));
    ready_si = (hold == 0);
    send(m, sh);
    cnt = 0;
    while (!valid_so && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    e = sb.pop_front();
    chk("latency", 64'(cnt), 64'(e.lat));
    chk("mant", {32'b0, mant_do}, {32'b0, e.mant});
    chk("guard", {63'b0, guard_do}, {63'b0, e.g});
    chk("round", {63'b0, round_do}, {63'b0, e.r});
    chk("sticky", {63'b0, sticky_do}, {63'b0, e.s});
    held_mant = mant_do;
    for (int i = 0; i < hold; i++) begin
      valid_si = 1'b1;
      mant_di  = ~m;
      @(posedge clk);
      #1;
      chk("hold_valid", {63'b0, valid_so}, 64'd1);
      chk("hold_ready", {63'b0, ready_so}, 64'd0);
      chk("hold_mant", {32'b0, mant_do}, {32'b0, held_mant});
    end
    valid_si = 1'b0;
    ready_si = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", {63'b0, valid_so}, 64'd0);
    chk("idle_ready", {63'b0, ready_so}, 64'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_si = 1'b0;
    kill_si  = 1'b0;
    ready_si = 1'b1;
    mant_di  = '0;
    shift_di = '0;
    #12;
    chk("rst_ready", {63'b0, ready_so}, 64'd1);
    chk("rst_valid", {63'b0, valid_so}, 64'd0);
    chk("rst_busy", {63'b0, busy_so}, 64'd0);
    chk("rst_out", {29'b0, mant_do, guard_do, round_do, sticky_do}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h8000_0000, 0, 0);
    run_op(32'h8000_0001, 1, 0);
    run_op(32'hFFFF_FFFF, 20, 0);
    run_op(32'h0000_0001, 40, 0);
    run_op(32'h0000_0000, 20, 0);
    run_op(32'hA5A5_A5A5, 34, 0);
    run_op(32'h1234_5678, 7, 4);

    // Kill in the second SHIFT cycle.
    send(32'hFFFF_FFFF, 20);
    @(posedge clk);
    #1;
    kill_si = 1'b1;
    @(posedge clk);
    #1;
    kill_si = 1'b0;
    chk("kill_ready", {63'b0, ready_so}, 64'd1);
    chk("kill_busy", {63'b0, busy_so}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("kill_no_valid", {63'b0, valid_so}, 64'd0);
    end
    run_op(32'h8000_0001, 1, 0);

    // Kill beats a same-cycle handshake in IDLE.
    @(negedge clk);
    valid_si = 1'b1;
    kill_si  = 1'b1;
    mant_di  = 32'hDEAD_BEEF;
    shift_di = 7'd3;
    @(posedge clk);
    #1;
    valid_si = 1'b0;
    kill_si  = 1'b0;
    chk("idle_kill_busy", {63'b0, busy_so}, 64'd0);

    // Asynchronous reset mid-operation.
    send(32'hFFFF_FFFF, 34);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy_so}, 64'd0);
    chk("midrst_out", {29'b0, mant_do, guard_do, round_do, sticky_do}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op($urandom, int'($urandom_range(0, 45)), int'($urandom_range(0, 2)));
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
